// File: rtl/pattern_history_table.sv
// Gshare pattern history table: 2**M two-bit saturating counters indexed by
// history XOR word-aligned PC, one-cycle registered prediction, mispredict stats.

module pht_counter (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       we_i,
    input  logic       taken_i,
    output logic [1:0] cnt_d_o
);
    logic [1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (we_i) begin
            if (taken_i && cnt_q != 2'b11)       cnt_d = cnt_q + 2'b01;
            else if (!taken_i && cnt_q != 2'b00) cnt_d = cnt_q - 2'b01;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= 2'b01;
        else          cnt_q <= cnt_d;
    end

    // Next-state value is exported so a same-cycle read sees the update.
    assign cnt_d_o = cnt_d;
endmodule

module pattern_history_table #(
    parameter int M       = 4,
    parameter int PC_BITS = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [M-1:0]       bhr_in,
    input  logic               pred_req,
    input  logic [PC_BITS-1:0] pred_pc,
    output logic               pred_valid,
    output logic               pred_taken,
    output logic [M-1:0]       pred_index,
    input  logic               upd_valid,
    input  logic [M-1:0]       upd_index,
    input  logic               upd_taken,
    input  logic               upd_mispredict,
    output logic [CNT_W-1:0]   mispredict_count
);
    localparam int DEPTH = 1 << M;

    logic [DEPTH-1:0][1:0] cnt_nxt;
    logic [M-1:0]          idx;
    logic                  valid_q, valid_d;
    logic                  taken_q, taken_d;
    logic [M-1:0]          index_q, index_d;
    logic [CNT_W-1:0]      mcnt_q, mcnt_d;
    logic                  unused_pc;

    assign idx       = bhr_in ^ pred_pc[M+1:2];
    assign unused_pc = ^{pred_pc[PC_BITS-1:M+2], pred_pc[1:0]};

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        pht_counter u_cnt (
            .clk     (clk),
            .reset_n (reset_n),
            .we_i    (upd_valid && (upd_index == M'(g))),
            .taken_i (upd_taken),
            .cnt_d_o (cnt_nxt[g])
        );
    end

    always_comb begin
        valid_d = pred_req;
        taken_d = taken_q;
        index_d = index_q;
        if (pred_req) begin
            taken_d = cnt_nxt[idx][1];
            index_d = idx;
        end
        mcnt_d = mcnt_q;
        if (upd_valid && upd_mispredict && mcnt_q != {CNT_W{1'b1}})
            mcnt_d = mcnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            taken_q <= 1'b0;
            index_q <= '0;
            mcnt_q  <= '0;
        end else begin
            valid_q <= valid_d;
            taken_q <= taken_d;
            index_q <= index_d;
            mcnt_q  <= mcnt_d;
        end
    end

    assign pred_valid       = valid_q;
    assign pred_taken       = taken_q;
    assign pred_index       = index_q;
    assign mispredict_count = mcnt_q;
endmodule

// File: tb/tb_pattern_history_table.sv
// Self-checking bench for pattern_history_table: reference table model feeds a
// scoreboard queue checked every cycle, plus directed per-feature checks.

module tb_pattern_history_table;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  bhr_in = '0;
    logic        pred_req = 1'b0;
    logic [31:0] pred_pc = '0;
    logic        pred_valid, pred_taken;
    logic [3:0]  pred_index;
    logic        upd_valid = 1'b0;
    logic [3:0]  upd_index = '0;
    logic        upd_taken = 1'b0;
    logic        upd_mispredict = 1'b0;
    logic [3:0]  mispredict_count;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic       vld;
        logic       tk;
        logic [3:0] idx;
        logic [3:0] cnt;
    } exp_t;

    exp_t       sb[$];
    logic       mon_en = 1'b0;
    logic [1:0] mtbl[16];
    logic [3:0] mcnt;
    logic       last_tk;
    logic [3:0] last_idx;

    pattern_history_table #(.M(4), .PC_BITS(32), .CNT_W(4)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .bhr_in           (bhr_in),
        .pred_req         (pred_req),
        .pred_pc          (pred_pc),
        .pred_valid       (pred_valid),
        .pred_taken       (pred_taken),
        .pred_index       (pred_index),
        .upd_valid        (upd_valid),
        .upd_index        (upd_index),
        .upd_taken        (upd_taken),
        .upd_mispredict   (upd_mispredict),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    always @(posedge clk) begin
        #2;
        if (mon_en) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_underflow got=empty exp=entry");
            end else begin
                exp_t e, g;
                e = sb.pop_front();
                g = {pred_valid, pred_taken, pred_index, mispredict_count};
                if (g !== e) begin
                    failures++;
                    $display("FAIL sb_cycle got vld=%0b tk=%0b idx=%0d cnt=%0d exp vld=%0b tk=%0b idx=%0d cnt=%0d",
                             g.vld, g.tk, g.idx, g.cnt, e.vld, e.tk, e.idx, e.cnt);
                end
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mtbl[i] = 2'b01;
        mcnt = '0; last_tk = 1'b0; last_idx = '0;
        sb.delete();
    endtask

    task automatic cyc(input logic req, input logic [3:0] bhr, input logic [31:0] pc,
                       input logic uv, input logic [3:0] ui, input logic ut, input logic um);
        logic [3:0] ix;
        @(negedge clk);
        pred_req = req; bhr_in = bhr; pred_pc = pc;
        upd_valid = uv; upd_index = ui; upd_taken = ut; upd_mispredict = um;
        if (uv) begin
            if (ut && mtbl[ui] != 2'b11)       mtbl[ui] = mtbl[ui] + 2'b01;
            else if (!ut && mtbl[ui] != 2'b00) mtbl[ui] = mtbl[ui] - 2'b01;
            if (um && mcnt != 4'hF) mcnt = mcnt + 4'd1;
        end
        if (req) begin
            ix = bhr ^ pc[5:2];
            last_tk = mtbl[ix][1];
            last_idx = ix;
        end
        sb.push_back('{req, last_tk, last_idx, mcnt});
        mon_en = 1'b1;
    endtask

    task automatic idle();
        cyc(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic predict(input logic [3:0] ix);
        cyc(1'b1, 4'd0, {26'd0, ix, 2'b00}, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic train(input logic [3:0] ix, input logic tk);
        cyc(1'b0, 4'd0, 32'd0, 1'b1, ix, tk, 1'b0);
    endtask

    task automatic expect_taken(input string name, input logic exp_tk);
        @(posedge clk); #3;
        checks++;
        if (pred_valid !== 1'b1 || pred_taken !== exp_tk) begin
            failures++;
            $display("FAIL %s got vld=%0b tk=%0b exp vld=1 tk=%0b", name, pred_valid, pred_taken, exp_tk);
        end
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        checks++;
        if ({pred_valid, pred_taken, pred_index, mispredict_count} !== 10'd0) begin
            failures++;
            $display("FAIL reset_outputs got vld=%0b tk=%0b idx=%0d cnt=%0d exp all 0",
                     pred_valid, pred_taken, pred_index, mispredict_count);
        end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #3;
        checks++;
        if (pred_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_vld got=%0b exp=0", pred_valid);
        end
    endtask

    task automatic test_basic();
        cyc(1'b1, 4'd0, 32'h0000_0010, 1'b0, 4'd0, 1'b0, 1'b0);
        @(posedge clk); #3;
        checks++;
        if (pred_valid !== 1'b1 || pred_taken !== 1'b0 || pred_index !== 4'd4) begin
            failures++;
            $display("FAIL basic_pred got vld=%0b tk=%0b idx=%0d exp vld=1 tk=0 idx=4",
                     pred_valid, pred_taken, pred_index);
        end
        idle();
        @(posedge clk); #3;
        checks++;
        if (pred_valid !== 1'b0 || pred_index !== 4'd4) begin
            failures++;
            $display("FAIL basic_hold got vld=%0b idx=%0d exp vld=0 idx=4", pred_valid, pred_index);
        end
    endtask

    task automatic test_saturation();
        repeat (3) train(4'd4, 1'b1);
        predict(4'd4); expect_taken("sat_up3", 1'b1);
        repeat (2) train(4'd4, 1'b1);
        predict(4'd4); expect_taken("sat_up5", 1'b1);
        train(4'd4, 1'b0);
        predict(4'd4); expect_taken("sat_dn1_from_top", 1'b1);
        repeat (3) train(4'd4, 1'b0);
        predict(4'd4); expect_taken("sat_dn4", 1'b0);
        train(4'd4, 1'b0);
        train(4'd4, 1'b1);
        predict(4'd4); expect_taken("sat_floor_then_up", 1'b0);
    endtask

    task automatic test_collision();
        // counter[4] is 01 here: same-cycle taken update must show as taken
        cyc(1'b1, 4'd0, 32'h0000_0010, 1'b1, 4'd4, 1'b1, 1'b0);
        expect_taken("collision_bypass", 1'b1);
        cyc(1'b1, 4'd0, 32'h0000_0014, 1'b1, 4'd4, 1'b1, 1'b0);
        expect_taken("different_idx", 1'b0);
    endtask

    task automatic test_hash();
        cyc(1'b1, 4'b1010, 32'h0000_0008, 1'b0, 4'd0, 1'b0, 1'b0);
        @(posedge clk); #3;
        checks++;
        if (pred_index !== 4'b1000) begin
            failures++;
            $display("FAIL hash_index got=%0d exp=8", pred_index);
        end
        train(4'd8, 1'b1);
        predict(4'd8); expect_taken("hash_idx8", 1'b1);
        predict(4'd2); expect_taken("hash_idx2", 1'b0);
        predict(4'd10); expect_taken("hash_idx10", 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++)
            cyc(1'($urandom_range(0, 3) != 0), 4'($urandom), $urandom,
                1'($urandom), 4'($urandom), 1'($urandom), 1'b0);
        idle();
    endtask

    task automatic test_stats();
        repeat (5) cyc(1'b0, 4'd0, 32'd0, 1'b1, 4'd3, 1'b1, 1'b1);
        cyc(1'b0, 4'd0, 32'd0, 1'b0, 4'd3, 1'b1, 1'b1);
        @(posedge clk); #3;
        checks++;
        if (mispredict_count !== 4'd5) begin
            failures++;
            $display("FAIL stats_ignore_invalid got=%0d exp=5", mispredict_count);
        end
        repeat (12) cyc(1'b0, 4'd0, 32'd0, 1'b1, 4'd3, 1'b0, 1'b1);
        @(posedge clk); #3;
        checks++;
        if (mispredict_count !== 4'd15) begin
            failures++;
            $display("FAIL stats_saturate got=%0d exp=15", mispredict_count);
        end
    endtask

    task automatic test_reset_mid();
        cyc(1'b1, 4'd0, 32'h0000_0020, 1'b1, 4'd5, 1'b1, 1'b1);
        @(posedge clk); #3;
        mon_en = 1'b0;
        checks++;
        if (pred_valid !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre_vld got=%0b exp=1", pred_valid);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (pred_valid !== 1'b0 || mispredict_count !== 4'd0 || pred_index !== 4'd0) begin
            failures++;
            $display("FAIL mid_async got vld=%0b cnt=%0d idx=%0d exp 0 0 0",
                     pred_valid, mispredict_count, pred_index);
        end
        model_reset();
        @(negedge clk);
        pred_req = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #3;
        checks++;
        if (pred_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_release_vld got=%0b exp=0", pred_valid);
        end
        predict(4'd4); expect_taken("mid_after_idx4", 1'b0);
        predict(4'd8); expect_taken("mid_after_idx8", 1'b0);
        predict(4'd15); expect_taken("mid_after_idx15", 1'b0);
        idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_collision();
        test_hash();
        test_back_to_back();
        test_stats();
        test_reset_mid();
        @(posedge clk); #4;
        mon_en = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
